rom_arbiter: RTL and testbench

Shares the single 256x16 synchronous instrument/pitch ROM between NUM_VOICES note players (each issues 8-bit word reads, e.g. pitch low/high word pairs). Round-robin arbitration with an optional per-requester lock, so multi-word fetches stay back-to-back, and a bounded lock hold. Read data returns on a shared bus with a per-requester valid strobe aligned to ROM latency. Sits between the voice array and the ROM; the ROM sees one address port only.

---
 rtl/rom_map_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 37 +++
 rtl/rom_arbiter.sv | 150 +++++++++++++++
 tb/tb_rom_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rom_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_map_pkg
// Description : Instrument/pitch ROM map constants and arbiter state encoding.
// Revision    : 1.0
// ============================================================================
package rom_map_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 16;

    localparam logic [7:0] NOTE_VALUE_BASE         = 8'h00;
    localparam logic [7:0] INSTRUMENT_LENGTHS_BASE = 8'h80;
    localparam logic [7:0] INSTRUMENT_VALUES_BASE  = 8'h84;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Rotate-and-find-first: first requester at or after i_ptr.
// Revision    : 1.0
// ============================================================================
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_winner,
    output logic             o_found
);

    logic [PTR_W:0] w_sum;

    // Explicit wrap keeps non-power-of-2 requester counts correct.
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            if (!o_found && i_req[w_sum[PTR_W-1:0]]) begin
                o_found  = 1'b1;
                o_winner = w_sum[PTR_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : Round-robin ROM arbiter with bounded per-requester lock and
//               latency-aligned per-requester read-valid strobes.
// Revision    : 1.0
// ============================================================================
module rom_arbiter
    import rom_map_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int ADDR_W      = ROM_ADDR_W,
    parameter int DATA_W      = ROM_DATA_W,
    parameter int ROM_LATENCY = 1,
    parameter int MAX_LOCK    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_VOICES-1:0]      i_req,
    input  logic [NUM_VOICES-1:0]      i_lock,
    input  logic [NUM_VOICES*ADDR_W-1:0] i_addr,
    output logic [NUM_VOICES-1:0]      o_gnt,
    output logic [NUM_VOICES-1:0]      o_rvalid,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [ADDR_W-1:0]          o_rom_addr,
    output logic                       o_rom_en,
    input  logic [DATA_W-1:0]          i_rom_data,
    output logic                       o_lock_timeout
);

    localparam int                  c_ptr_w    = $clog2(NUM_VOICES);
    localparam logic [c_ptr_w-1:0]  c_last     = c_ptr_w'(NUM_VOICES - 1);
    localparam logic [3:0]          c_max_lock = 4'(MAX_LOCK);

    arb_state_t          r_state, w_state_nxt;
    logic [c_ptr_w-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [c_ptr_w-1:0]  r_owner, w_owner_nxt;
    logic [3:0]          r_lock_cnt, w_lock_cnt_nxt;
    logic                r_lock_timeout, w_timeout;

    logic [c_ptr_w-1:0]  w_pick_idx;
    logic                w_pick_found;
    logic                w_grant;
    logic [c_ptr_w-1:0]  w_gnt_idx;
    logic [NUM_VOICES-1:0] w_gnt;
    logic [ADDR_W-1:0]   w_rom_addr;

    logic [NUM_VOICES-1:0] r_vpipe [ROM_LATENCY];

    rr_priority_pick #(
        .N     (NUM_VOICES),
        .PTR_W (c_ptr_w)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_pick_idx),
        .o_found  (w_pick_found)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        w_grant        = 1'b0;
        w_gnt_idx      = '0;
        w_timeout      = 1'b0;
        case (r_state)
            ARB: begin
                if (w_pick_found) begin
                    w_grant      = 1'b1;
                    w_gnt_idx    = w_pick_idx;
                    w_rr_ptr_nxt = (w_pick_idx == c_last) ? '0 : w_pick_idx + 1'b1;
                    if (i_lock[w_pick_idx]) begin
                        w_state_nxt    = LOCKED;
                        w_owner_nxt    = w_pick_idx;
                        w_lock_cnt_nxt = 4'd1;
                    end
                end
            end
            LOCKED: begin
                // Owner absent means the lock is abandoned: idle one cycle, no pulse.
                if (i_req[r_owner]) begin
                    w_grant        = 1'b1;
                    w_gnt_idx      = r_owner;
                    w_lock_cnt_nxt = r_lock_cnt + 4'd1;
                    if (!i_lock[r_owner]) begin
                        w_state_nxt = ARB;
                    end else if (r_lock_cnt + 4'd1 == c_max_lock) begin
                        w_state_nxt = ARB;
                        w_timeout   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_comb begin
        w_gnt      = '0;
        w_rom_addr = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (w_grant && (w_gnt_idx == c_ptr_w'(k))) begin
                w_gnt[k]   = 1'b1;
                w_rom_addr = i_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ARB;
            r_rr_ptr       <= '0;
            r_owner        <= '0;
            r_lock_cnt     <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_owner        <= w_owner_nxt;
            r_lock_cnt     <= w_lock_cnt_nxt;
            r_lock_timeout <= w_timeout;
        end
    end

    // Grant delay line matching ROM latency; reset drops in-flight strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_vpipe[i] <= '0;
            end
        end else begin
            r_vpipe[0] <= w_gnt;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    assign o_gnt          = w_gnt;
    assign o_rom_addr     = w_rom_addr;
    assign o_rom_en       = |w_gnt;
    assign o_rvalid       = r_vpipe[ROM_LATENCY-1];
    assign o_rdata        = i_rom_data;
    assign o_lock_timeout = r_lock_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Directed self-checking bench for rom_arbiter (4 voices,
//               ROM latency 1, MAX_LOCK 4) with a behavioural ROM.
// Revision    : 1.0
// ============================================================================
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] addr;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [15:0] rdata;
    logic [7:0]  rom_addr;
    logic        rom_en;
    logic [15:0] rom_q;
    logic        lock_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_arbiter #(
        .NUM_VOICES  (4),
        .ADDR_W      (8),
        .DATA_W      (16),
        .ROM_LATENCY (1),
        .MAX_LOCK    (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req          (req),
        .i_lock         (lock),
        .i_addr         (addr),
        .o_gnt          (gnt),
        .o_rvalid       (rvalid),
        .o_rdata        (rdata),
        .o_rom_addr     (rom_addr),
        .o_rom_en       (rom_en),
        .i_rom_data     (rom_q),
        .o_lock_timeout (lock_timeout)
    );

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        return {~a, a};
    endfunction

    // Synchronous ROM, one cycle latency
    always @(posedge clk) begin
        if (rom_en) rom_q <= rom_word(rom_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks one cycle at the falling edge, then advances to just past the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] eg, input logic [7:0] ea,
                       input logic [3:0] ev, input logic [7:0] va, input logic et);
        @(negedge clk);
        chk({tag, ".gnt"},     {28'd0, gnt},        {28'd0, eg});
        chk({tag, ".addr"},    {24'd0, rom_addr},   {24'd0, ea});
        chk({tag, ".en"},      {31'd0, rom_en},     {31'd0, |eg});
        chk({tag, ".rvalid"},  {28'd0, rvalid},     {28'd0, ev});
        if (ev != 4'd0) chk({tag, ".rdata"}, {16'd0, rdata}, {16'd0, rom_word(va)});
        chk({tag, ".timeout"}, {31'd0, lock_timeout}, {31'd0, et});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        addr  = 32'h0;
        @(posedge clk);
        #1;
        cyc("reset", 4'b0000, 8'h00, 4'b0000, 8'h00, 1'b0);
        rst_n = 1'b1;
        cyc("idle", 4'b0000, 8'h00, 4'b0000, 8'h00, 1'b0);

        // Fairness: all four requesting, pointer starts at 0
        addr = {8'h33, 8'h32, 8'h31, 8'h30};
        req  = 4'b1111;
        cyc("fair0", 4'b0001, 8'h30, 4'b0000, 8'h00, 1'b0);
        cyc("fair1", 4'b0010, 8'h31, 4'b0001, 8'h30, 1'b0);
        cyc("fair2", 4'b0100, 8'h32, 4'b0010, 8'h31, 1'b0);
        cyc("fair3", 4'b1000, 8'h33, 4'b0100, 8'h32, 1'b0);
        cyc("fair4", 4'b0001, 8'h30, 4'b1000, 8'h33, 1'b0);
        req = 4'b0000;
        cyc("fair5", 4'b0000, 8'h00, 4'b0001, 8'h30, 1'b0);

        // Single requester
        addr[7:0] = 8'h10;
        req = 4'b0001;
        cyc("single0", 4'b0001, 8'h10, 4'b0000, 8'h00, 1'b0);
        req = 4'b0000;
        cyc("single1", 4'b0000, 8'h00, 4'b0001, 8'h10, 1'b0);

        // Grant to last requester wraps pointer to 0
        req = 4'b1000;
        cyc("wrap", 4'b1000, 8'h33, 4'b0000, 8'h00, 1'b0);

        // Lock pair: 0 locks once, 2 waits two cycles
        addr[7:0]   = 8'h20;
        addr[23:16] = 8'h40;
        req  = 4'b0101;
        lock = 4'b0001;
        cyc("lp0", 4'b0001, 8'h20, 4'b1000, 8'h33, 1'b0);
        addr[7:0] = 8'h21;
        lock = 4'b0000;
        cyc("lp1", 4'b0001, 8'h21, 4'b0001, 8'h20, 1'b0);
        req = 4'b0100;
        cyc("lp2", 4'b0100, 8'h40, 4'b0001, 8'h21, 1'b0);
        req = 4'b0000;
        cyc("lp3", 4'b0000, 8'h00, 4'b0100, 8'h40, 1'b0);

        // Lock timeout: four grants to 1, then 3, with one-cycle pulse
        req = 4'b1000;
        cyc("to_pre", 4'b1000, 8'h33, 4'b0000, 8'h00, 1'b0);
        addr[15:8]  = 8'h50;
        addr[31:24] = 8'h70;
        req  = 4'b1010;
        lock = 4'b0010;
        cyc("to0", 4'b0010, 8'h50, 4'b1000, 8'h33, 1'b0);
        cyc("to1", 4'b0010, 8'h50, 4'b0010, 8'h50, 1'b0);
        cyc("to2", 4'b0010, 8'h50, 4'b0010, 8'h50, 1'b0);
        cyc("to3", 4'b0010, 8'h50, 4'b0010, 8'h50, 1'b0);
        cyc("to4", 4'b1000, 8'h70, 4'b0010, 8'h50, 1'b1);
        req  = 4'b0000;
        lock = 4'b0000;
        cyc("to5", 4'b0000, 8'h00, 4'b1000, 8'h70, 1'b0);

        // Lock abandon: owner 0 drops, req3 blocked one idle cycle, ARB resumes at 1
        addr[7:0] = 8'h60;
        req  = 4'b0001;
        lock = 4'b0001;
        cyc("ab0", 4'b0001, 8'h60, 4'b0000, 8'h00, 1'b0);
        req  = 4'b1000;
        lock = 4'b0000;
        cyc("ab1", 4'b0000, 8'h00, 4'b0001, 8'h60, 1'b0);
        req = 4'b1001;
        cyc("ab2", 4'b1000, 8'h70, 4'b0000, 8'h00, 1'b0);
        req = 4'b0000;
        cyc("ab3", 4'b0000, 8'h00, 4'b1000, 8'h70, 1'b0);

        // Async reset the cycle after a grant
        req = 4'b0010;
        cyc("rs0", 4'b0010, 8'h50, 4'b0000, 8'h00, 1'b0);
        req = 4'b0000;
        chk("rs.pre_rvalid", {28'd0, rvalid}, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("rs.async_rvalid", {28'd0, rvalid}, 32'h0);
        cyc("rs_hold", 4'b0000, 8'h00, 4'b0000, 8'h00, 1'b0);
        rst_n = 1'b1;
        req = 4'b1111;
        cyc("rs_post", 4'b0001, 8'h60, 4'b0000, 8'h00, 1'b0);
        req = 4'b0000;
        cyc("rs_post1", 4'b0000, 8'h00, 4'b0001, 8'h60, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
